// File: rtl/emu_synth_pkg.sv
// Shared types, constants and table generator for the GPS synthesizer emulator chain.
package emu_synth_pkg;

    localparam int unsigned LUT_BITS       = 8;
    localparam int unsigned OUT_W          = 12;
    localparam int unsigned AMP_W          = 8;
    localparam int unsigned EPOCHS_PER_BIT = 20;
    localparam int unsigned PHASE_W        = 32;
    localparam int unsigned NAV_W          = 32;
    localparam int unsigned EPOCH_W        = $clog2(EPOCHS_PER_BIT);
    localparam int unsigned BIT_IDX_W      = $clog2(NAV_W);

    // Fibonacci LFSR x^16 + x^14 + x^13 + x^11 + 1
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    localparam int SAMPLE_MAX = int'((1 << (OUT_W - 1)) - 1);

    typedef logic signed [OUT_W-1:0] sample_t;
    typedef logic [NAV_W-1:0]        nav_word_t;

    localparam sample_t PEAK = sample_t'(SAMPLE_MAX);

    // One full-wave sine entry; the second half is the exact negation of the first
    // so the table is symmetric. Integer rational approximation (exact at 0/90/180/270).
    function automatic sample_t sine_entry(input int idx);
        longint p;
        longint k;
        longint t;
        longint num;
        longint den;
        longint mag;
        p   = longint'(1) << (LUT_BITS - 1);
        k   = longint'(idx) % p;
        t   = k * (p - k);
        num = 16 * longint'(SAMPLE_MAX) * t;
        den = 5 * p * p - 4 * t;
        mag = (num + den / 2) / den;
        if (longint'(idx) >= p) begin
            mag = -mag;
        end
        return sample_t'(mag);
    endfunction

    // Next LFSR state: shift left, parity of tapped bits enters at bit 0
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/emu_sine_lut.sv
// Registered cos/sin lookup over a full-wave sine table, one clock of latency.
module emu_sine_lut
    import emu_synth_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic [LUT_BITS-1:0] addr,
    output sample_t             cos_val,
    output sample_t             sin_val
);

    localparam int unsigned         TAB_N   = 1 << LUT_BITS;
    localparam logic [LUT_BITS-1:0] QUARTER = LUT_BITS'(TAB_N / 4);

    sample_t             tab [TAB_N];
    logic [LUT_BITS-1:0] cos_addr;

    for (genvar g = 0; g < int'(TAB_N); g++) begin : g_tab
        localparam sample_t ENTRY = sine_entry(g);
        assign tab[g] = ENTRY;
    end

    // cos(x) = sin(x + 90 deg); address wraps naturally
    assign cos_addr = addr + QUARTER;

    // Table read into output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cos_val <= '0;
            sin_val <= '0;
        end else if (en) begin
            cos_val <= tab[cos_addr];
            sin_val <= tab[addr];
        end
    end

endmodule

// File: rtl/emu_sat_modulator.sv
// One-satellite baseband modulator: code chip x nav bit x carrier, amplitude scaled.
// Optional LFSR dither on I/Q enabled by defining EMU_SAT_MOD_DITHER_EN.
module emu_sat_modulator
    import emu_synth_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    dv_in,
    input  logic                    q,
    input  logic                    epoch_in,
    input  logic [PHASE_W-1:0]      carrier_freq,
    input  logic [AMP_W-1:0]        amp,
    input  logic [NAV_W-1:0]        nav_word,
    input  logic                    nav_valid,
    output logic                    nav_ready,
    output logic                    dv_out,
    output logic signed [OUT_W-1:0] i_out,
    output logic signed [OUT_W-1:0] q_out,
    output logic                    nav_bit_out,
    output logic                    nav_underflow
);

    // Scale by amplitude on the magnitude so positive and negative peaks match,
    // then apply the combined table/data sign.
    function automatic sample_t scale(input sample_t v, input logic [AMP_W-1:0] a,
                                      input logic neg);
        logic [OUT_W-1:0]       mag;
        logic [OUT_W+AMP_W-1:0] prod;
        sample_t                res;
        mag  = v[OUT_W-1] ? OUT_W'(-v) : OUT_W'(v);
        prod = (OUT_W + AMP_W)'(mag) * (OUT_W + AMP_W)'(a);
        res  = OUT_W'(prod >> AMP_W);
        return (neg ^ v[OUT_W-1]) ? -res : res;
    endfunction

    logic [PHASE_W-1:0]   phase_acc;
    logic [EPOCH_W-1:0]   epoch_cnt;
    logic [BIT_IDX_W-1:0] bit_idx;
    nav_word_t            cur_word;
    nav_word_t            buf_word;
    logic                 cur_valid;
    logic                 buf_valid;

    logic [EPOCH_W-1:0]   epoch_cnt_nxt;
    logic [BIT_IDX_W-1:0] bit_idx_nxt;
    nav_word_t            cur_word_nxt;
    logic                 cur_valid_nxt;
    logic                 buf_valid_nxt;
    logic                 load_c;
    logic                 accept_c;
    logic                 underflow_set_c;
    logic                 nav_bit_c;

    logic                 s1_valid;
    logic [LUT_BITS-1:0]  s1_addr;
    logic                 s1_sign;
    logic                 s1_nav;
    logic [AMP_W-1:0]     s1_amp;
    logic                 s2_valid;
    logic                 s2_sign;
    logic                 s2_nav;
    logic [AMP_W-1:0]     s2_amp;
    sample_t              cos_val;
    sample_t              sin_val;

    // Bit timing, word boundary handling and the nav bit for the current sample
    always_comb begin
        epoch_cnt_nxt   = epoch_cnt;
        bit_idx_nxt     = bit_idx;
        cur_word_nxt    = cur_word;
        cur_valid_nxt   = cur_valid;
        load_c          = 1'b0;
        underflow_set_c = 1'b0;
        if (dv_in && epoch_in) begin
            if (epoch_cnt == EPOCH_W'(EPOCHS_PER_BIT - 1)) begin
                epoch_cnt_nxt = '0;
                if (cur_valid && (bit_idx != BIT_IDX_W'(NAV_W - 1))) begin
                    bit_idx_nxt = bit_idx + BIT_IDX_W'(1);
                end else begin
                    bit_idx_nxt = '0;
                    if (buf_valid) begin
                        cur_word_nxt  = buf_word;
                        cur_valid_nxt = 1'b1;
                        load_c        = 1'b1;
                    end else begin
                        cur_valid_nxt   = 1'b0;
                        underflow_set_c = cur_valid;
                    end
                end
            end else begin
                epoch_cnt_nxt = epoch_cnt + EPOCH_W'(1);
            end
        end
        accept_c      = nav_valid && !buf_valid;
        buf_valid_nxt = load_c ? 1'b0 : (accept_c ? 1'b1 : buf_valid);
        nav_bit_c     = cur_valid_nxt && cur_word_nxt[BIT_IDX_W'(NAV_W - 1) - bit_idx_nxt];
    end

    // Nav word state, handshake and sticky underflow
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            epoch_cnt     <= '0;
            bit_idx       <= '0;
            cur_word      <= '0;
            cur_valid     <= 1'b0;
            buf_word      <= '0;
            buf_valid     <= 1'b0;
            nav_ready     <= 1'b1;
            nav_underflow <= 1'b0;
        end else begin
            epoch_cnt <= epoch_cnt_nxt;
            bit_idx   <= bit_idx_nxt;
            cur_word  <= cur_word_nxt;
            cur_valid <= cur_valid_nxt;
            buf_valid <= buf_valid_nxt;
            nav_ready <= !buf_valid_nxt;
            if (accept_c) begin
                buf_word <= nav_word;
            end
            if (underflow_set_c) begin
                nav_underflow <= 1'b1;
            end
        end
    end

    // Carrier NCO and stage 1: table address, data sign, amplitude capture
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_acc <= '0;
            s1_valid  <= 1'b0;
            s1_addr   <= '0;
            s1_sign   <= 1'b0;
            s1_nav    <= 1'b0;
            s1_amp    <= '0;
        end else begin
            s1_valid <= dv_in;
            if (dv_in) begin
                phase_acc <= phase_acc + carrier_freq;
                s1_addr   <= phase_acc[PHASE_W-1 -: LUT_BITS];
                s1_sign   <= q ^ nav_bit_c;
                s1_nav    <= nav_bit_c;
                s1_amp    <= amp;
            end
        end
    end

    emu_sine_lut u_lut (
        .clk     (clk),
        .reset   (reset),
        .en      (s1_valid),
        .addr    (s1_addr),
        .cos_val (cos_val),
        .sin_val (sin_val)
    );

    // Stage 2: carry sideband alongside the table read
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s2_valid <= 1'b0;
            s2_sign  <= 1'b0;
            s2_nav   <= 1'b0;
            s2_amp   <= '0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_sign <= s1_sign;
                s2_nav  <= s1_nav;
                s2_amp  <= s1_amp;
            end
        end
    end

`ifdef EMU_SAT_MOD_DITHER_EN
    logic [15:0]       lfsr;
    logic signed [1:0] s1_dith;
    logic signed [1:0] s2_dith;

    // Add the signed dither and clip to the symmetric table peak
    function automatic sample_t add_dither(input sample_t v, input logic signed [1:0] d);
        logic signed [OUT_W:0] sum;
        sum = (OUT_W + 1)'(v) + (OUT_W + 1)'(d);
        if (sum > (OUT_W + 1)'(PEAK)) begin
            sum = (OUT_W + 1)'(PEAK);
        end else if (sum < -(OUT_W + 1)'(PEAK)) begin
            sum = -(OUT_W + 1)'(PEAK);
        end
        return sample_t'(sum);
    endfunction

    // Dither LFSR steps per sample; its low bits follow the sample down the pipe
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr    <= LFSR_SEED;
            s1_dith <= '0;
            s2_dith <= '0;
        end else begin
            if (dv_in) begin
                lfsr    <= lfsr_next(lfsr);
                s1_dith <= lfsr[1:0];
            end
            if (s1_valid) begin
                s2_dith <= s1_dith;
            end
        end
    end
`endif

    // Stage 3: multiply/negate into the output registers, hold between strobes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dv_out      <= 1'b0;
            i_out       <= '0;
            q_out       <= '0;
            nav_bit_out <= 1'b0;
        end else begin
            dv_out <= s2_valid;
            if (s2_valid) begin
`ifdef EMU_SAT_MOD_DITHER_EN
                i_out <= add_dither(scale(cos_val, s2_amp, s2_sign), s2_dith);
                q_out <= add_dither(scale(sin_val, s2_amp, s2_sign), s2_dith);
`else
                i_out <= scale(cos_val, s2_amp, s2_sign);
                q_out <= scale(sin_val, s2_amp, s2_sign);
`endif
                nav_bit_out <= s2_nav;
            end
        end
    end

endmodule

// File: tb/tb_emu_sat_modulator.sv
// Directed bench for emu_sat_modulator: carrier, code sign, nav timing, buffering, reset.
`timescale 1ns/1ps
module tb_emu_sat_modulator;
    import emu_synth_pkg::*;

    logic                    clk = 1'b0;
    logic                    reset = 1'b1;
    logic                    dv_in = 1'b0;
    logic                    q = 1'b0;
    logic                    epoch_in = 1'b0;
    logic [31:0]             carrier_freq = '0;
    logic [AMP_W-1:0]        amp = '0;
    logic [31:0]             nav_word = '0;
    logic                    nav_valid = 1'b0;
    logic                    nav_ready;
    logic                    dv_out;
    logic signed [OUT_W-1:0] i_out;
    logic signed [OUT_W-1:0] q_out;
    logic                    nav_bit_out;
    logic                    nav_underflow;

    int total = 0;
    int bad   = 0;

    emu_sat_modulator dut (
        .clk           (clk),
        .reset         (reset),
        .dv_in         (dv_in),
        .q             (q),
        .epoch_in      (epoch_in),
        .carrier_freq  (carrier_freq),
        .amp           (amp),
        .nav_word      (nav_word),
        .nav_valid     (nav_valid),
        .nav_ready     (nav_ready),
        .dv_out        (dv_out),
        .i_out         (i_out),
        .q_out         (q_out),
        .nav_bit_out   (nav_bit_out),
        .nav_underflow (nav_underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

`ifdef EMU_SAT_MOD_DITHER_EN
    task automatic chk_rng(input string tag, input logic signed [31:0] obs, input int exp);
        int lo;
        int hi;
        lo = (exp - 2 < -2047) ? -2047 : exp - 2;
        hi = (exp + 1 > 2047) ? 2047 : exp + 1;
        total++;
        assert (obs >= lo && obs <= hi) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
        end
    endtask
`endif

    task automatic chk_iq(input string tag, input int ei, input int eq);
`ifdef EMU_SAT_MOD_DITHER_EN
        chk_rng({tag, "_i"}, i_out, ei);
        chk_rng({tag, "_q"}, q_out, eq);
`else
        chk({tag, "_i"}, i_out, ei);
        chk({tag, "_q"}, q_out, eq);
`endif
    endtask

    // One isolated sample from a negedge; checks dv_out lands exactly 3 clocks later
    task automatic pulse(input logic qv, input logic ep);
        dv_in    = 1'b1;
        q        = qv;
        epoch_in = ep;
        @(negedge clk);
        dv_in     = 1'b0;
        epoch_in  = 1'b0;
        nav_valid = 1'b0;
        chk("lat1", dv_out, 0);
        @(negedge clk);
        chk("lat2", dv_out, 0);
        @(negedge clk);
        chk("lat3", dv_out, 1);
    endtask

    // Back-to-back samples with q=0, then drain the pipeline
    task automatic stream(input int n, input logic ep);
        for (int i = 0; i < n; i++) begin
            dv_in    = 1'b1;
            q        = 1'b0;
            epoch_in = ep;
            @(negedge clk);
        end
        dv_in    = 1'b0;
        epoch_in = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] w1;
        int          nb;
        w1 = 32'hA000_0000;

        carrier_freq = 32'h4000_0000;
        amp          = 8'd255;
        repeat (2) @(negedge clk);
        chk("rst_dv", dv_out, 0);
        chk("rst_i", i_out, 0);
        chk("rst_q", q_out, 0);
        chk("rst_nav", nav_bit_out, 0);
        chk("rst_unf", nav_underflow, 0);
        chk("rst_rdy", nav_ready, 1);
        reset = 1'b0;
        @(negedge clk);

        // Quarter-rate carrier
        pulse(1'b0, 1'b0); chk_iq("qr0", 2039, 0);
        @(negedge clk);
        chk("hold_dv", dv_out, 0);
        chk_iq("hold", 2039, 0);
        pulse(1'b0, 1'b0); chk_iq("qr90", 0, 2039);
        pulse(1'b0, 1'b0); chk_iq("qr180", -2039, 0);
        pulse(1'b0, 1'b0); chk_iq("qr270", 0, -2039);

        // Code chip sign
        pulse(1'b1, 1'b0); chk_iq("cs0", -2039, 0);
        pulse(1'b0, 1'b0); chk_iq("cs90", 0, 2039);
        pulse(1'b1, 1'b0); chk_iq("cs180", 2039, 0);
        pulse(1'b1, 1'b0); chk_iq("cs270", 0, 2039);

        // Amplitude; freezing the carrier at 90 degrees afterwards
        amp = 8'd0;
        pulse(1'b0, 1'b0); chk_iq("amp0", 0, 0);
        amp          = 8'd128;
        carrier_freq = 32'h0;
        pulse(1'b0, 1'b0); chk_iq("amp128", 0, 1023);
        amp = 8'd255;

        // Nav word load and bit timing at 1023-sample epochs
        chk("rdy_empty", nav_ready, 1);
        nav_word  = w1;
        nav_valid = 1'b1;
        @(negedge clk);
        nav_valid = 1'b0;
        chk("rdy_full", nav_ready, 0);
        for (int k = 1; k <= 60; k++) begin
            stream(1021, 1'b0);
            nb = (k >= 20) ? int'(w1[31 - (k / 20 - 1)]) : 0;
            pulse(1'b0, 1'b1);
            chk($sformatf("nav_ep%0d", k), nav_bit_out, nb);
            chk_iq($sformatf("navq_ep%0d", k), 0, (nb != 0) ? -2039 : 2039);
            if (k == 19) chk("rdy_ep19", nav_ready, 0);
            if (k == 20) chk("rdy_ep20", nav_ready, 1);
            pulse(1'b0, 1'b0);
            chk($sformatf("navhold_ep%0d", k), nav_bit_out, nb);
        end

        // Run out the word with one epoch per sample
        stream(579, 1'b1);
        pulse(1'b0, 1'b1);
        chk("ep640_nav", nav_bit_out, 0);
        chk("ep640_unf", nav_underflow, 0);
        stream(19, 1'b1);
        nav_word  = 32'hC000_0000;
        nav_valid = 1'b1;
        chk("rdy_bnd", nav_ready, 1);
        pulse(1'b0, 1'b1);
        chk("ep660_nav", nav_bit_out, 0);
        chk("ep660_unf", nav_underflow, 1);
        chk("ep660_rdy", nav_ready, 0);
        chk_iq("ep660", 0, 2039);
        stream(19, 1'b1);
        pulse(1'b0, 1'b1);
        chk("ep680_nav", nav_bit_out, 1);
        chk("ep680_unf", nav_underflow, 1);
        chk("ep680_rdy", nav_ready, 1);
        chk_iq("ep680", 0, -2039);

        // Asynchronous reset while streaming
        carrier_freq = 32'h4000_0000;
        dv_in        = 1'b1;
        q            = 1'b0;
        repeat (5) @(negedge clk);
        chk("pre_rst_dv", dv_out, 1);
        chk("pre_rst_nav", nav_bit_out, 1);
        chk_iq("pre_rst", 0, 2039);
        #2 reset = 1'b1;
        #1;
        chk("arst_dv", dv_out, 0);
        chk("arst_i", i_out, 0);
        chk("arst_q", q_out, 0);
        chk("arst_nav", nav_bit_out, 0);
        chk("arst_unf", nav_underflow, 0);
        chk("arst_rdy", nav_ready, 1);
        @(negedge clk);
        dv_in = 1'b0;
        reset = 1'b0;
        pulse(1'b0, 1'b0); chk_iq("post0", 2039, 0);
        chk("post0_nav", nav_bit_out, 0);
        pulse(1'b0, 1'b0); chk_iq("post90", 0, 2039);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
